// File: rtl/avalon_pkg.sv
// Shared types and lane-mask constants for the Avalon-MM bus master.
package avalon_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUS    = 2'd1,
    RDWAIT = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [3:0] LANE_BYTE    = 4'b0001;
  localparam logic [3:0] LANE_HALF_LO = 4'b0011;
  localparam logic [3:0] LANE_HALF_HI = 4'b1100;
  localparam logic [3:0] LANE_WORD    = 4'b1111;

endpackage

// File: rtl/avalon_lane_align.sv
// Little-endian lane steering: byteenable, lane-shifted store data and
// extended load data. Pure combinational.
module avalon_lane_align
  import avalon_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [4:0]  sh;
  logic [31:0] wmask;
  logic [31:0] rsh;

  always_comb begin
    be        = LANE_WORD;
    sh        = 5'd0;
    wmask     = wdata;
    rsh       = 32'h0;
    rdata_ext = 32'h0;
    case (size)
      SIZE_BYTE: begin
        be    = LANE_BYTE << addr_lo;
        sh    = {addr_lo, 3'b000};
        wmask = {24'h0, wdata[7:0]};
      end
      SIZE_HALF: begin
        be    = addr_lo[1] ? LANE_HALF_HI : LANE_HALF_LO;
        sh    = {addr_lo[1], 4'b0000};
        wmask = {16'h0, wdata[15:0]};
      end
      default: ;  // reserved size 3 behaves as word
    endcase
    wdata_lane = wmask << sh;
    rsh        = rdata >> sh;
    case (size)
      SIZE_BYTE: rdata_ext = {{24{sgn & rsh[7]}},  rsh[7:0]};
      SIZE_HALF: rdata_ext = {{16{sgn & rsh[15]}}, rsh[15:0]};
      default:   rdata_ext = rsh;
    endcase
  end

endmodule

// File: rtl/avalon_bus_master.sv
// CPU load/store to Avalon-MM master bridge with fixed read latency.
// Optional misalignment trap: define AVALON_MASTER_ALIGN_CHECK_EN.
module avalon_bus_master
  import avalon_pkg::*;
#(
  parameter int RDATA_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  localparam logic [2:0] LAT = 3'(RDATA_LATENCY);

  state_e      state_q, state_d;
  logic        live_q;
  logic        is_wr_q, sgn_q;
  logic [1:0]  lo_q, size_q;
  logic [2:0]  lat_q;
  logic        accept, misal, idle;
  logic [1:0]  al_lo, al_size;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;

  assign idle      = (state_q == IDLE);
  // live_q keeps ready low until the first clock edge after reset release
  assign req_ready = live_q && idle;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == RESP);

`ifdef AVALON_MASTER_ALIGN_CHECK_EN
  assign misal = ((req_size == SIZE_HALF) && req_addr[0]) ||
                 (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misal   = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // Request fields steer the lanes at accept; registered copies afterwards.
  assign al_lo   = idle ? req_addr[1:0] : lo_q;
  assign al_size = idle ? req_size      : size_q;

  avalon_lane_align u_align (
    .addr_lo    (al_lo),
    .size       (al_size),
    .sgn        (sgn_q),
    .wdata      (req_wdata),
    .rdata      (readdata),
    .be         (al_be),
    .wdata_lane (al_wdata),
    .rdata_ext  (al_rdata)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = misal ? RESP : BUS;
      BUS:     if (!waitrequest) state_d = is_wr_q ? RESP : RDWAIT;
      RDWAIT:  if (lat_q == LAT) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      live_q     <= 1'b0;
      is_wr_q    <= 1'b0;
      sgn_q      <= 1'b0;
      lo_q       <= 2'b00;
      size_q     <= 2'b00;
      lat_q      <= 3'd0;
      address    <= 32'h0;
      read       <= 1'b0;
      write      <= 1'b0;
      byteenable <= 4'h0;
      writedata  <= 32'h0;
      rsp_rdata  <= 32'h0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      case (state_q)
        IDLE: if (accept) begin
          is_wr_q   <= req_write;
          sgn_q     <= req_signed;
          lo_q      <= req_addr[1:0];
          size_q    <= req_size;
          rsp_rdata <= 32'h0;
          if (!misal) begin
            address    <= {req_addr[31:2], 2'b00};
            read       <= !req_write;
            write      <= req_write;
            byteenable <= al_be;
            writedata  <= req_write ? al_wdata : 32'h0;
          end
        end
        BUS: if (!waitrequest) begin
          read  <= 1'b0;
          write <= 1'b0;
          lat_q <= 3'd1;
        end
        RDWAIT: begin
          if (lat_q == LAT) rsp_rdata <= al_rdata;
          else              lat_q     <= lat_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef AVALON_MASTER_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rsp_err <= 1'b0;
    else if (accept) rsp_err <= misal;
  end
`endif

endmodule

// File: tb/tb_avalon_bus_master.sv
// Randomized bench for avalon_bus_master against a lane/latency reference model.
module tb_avalon_bus_master;

  localparam int LAT = 1;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_signed = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        rsp_valid, rsp_err, read, write;
  logic [31:0] rsp_rdata, address, writedata;
  logic [3:0]  byteenable;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = '0;

  int checks = 0, errors = 0;

  avalon_bus_master #(.RDATA_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_signed(req_signed), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .address(address), .read(read),
    .write(write), .byteenable(byteenable), .writedata(writedata),
    .waitrequest(waitrequest), .readdata(readdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: plain arithmetic on the access size and address.
  function automatic int m_shift(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 8 * int'(a[1:0]);
    if (sz == 2'd1) return 16 * int'(a[1]);
    return 0;
  endfunction

  function automatic int m_bits(input logic [1:0] sz);
    return (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 4'(1 << a[1:0]);
    if (sz == 2'd1) return a[1] ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_mask(input logic [1:0] sz);
    if (m_bits(sz) == 32) return 32'hFFFF_FFFF;
    return (32'd1 << m_bits(sz)) - 32'd1;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] a,
                                          input logic [31:0] wd);
    return (wd & m_mask(sz)) << m_shift(sz, a);
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [31:0] a,
                                         input bit sgn, input logic [31:0] rd);
    logic [31:0] v;
    int b;
    b = m_bits(sz);
    v = (rd >> m_shift(sz, a)) & m_mask(sz);
    if (sgn && b < 32 && v >= (32'd1 << (b - 1))) v = v - (32'd1 << b);
    return v;
  endfunction

  function automatic bit m_misal(input logic [1:0] sz, input logic [31:0] a);
`ifdef AVALON_MASTER_ALIGN_CHECK_EN
    return (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'b00);
`else
    return (sz == 2'd0 && a == 32'h0) && 1'b0;
`endif
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_txn(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                         input bit sgn, input logic [31:0] wd, input logic [31:0] rd,
                         input int ws, output logic [31:0] got);
    bit          err, done;
    int          held, acc_cyc, rsp_cyc, exp_cyc;
    logic [31:0] exp_rd;
    err     = m_misal(sz, a);
    exp_rd  = (wr || err) ? 32'h0 : m_load(sz, a, sgn, rd);
    exp_cyc = err ? 0 : (wr ? ws + 1 : ws + 1 + LAT);
    got     = '0;
    chk("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_size = sz;
    req_signed = sgn; req_wdata = wd;
    @(negedge clk);
    held = 0; acc_cyc = -1; rsp_cyc = -1; done = 0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      if (read || write) begin
        held++;
        chk("rw_excl", 32'(read && write), 32'd0);
        chk("dir", 32'(write), 32'(wr));
        chk("address", address, {a[31:2], 2'b00});
        chk("byteenable", 32'(byteenable), 32'(m_be(sz, a)));
        chk("writedata", writedata, wr ? m_wdata(sz, a, wd) : 32'h0);
        waitrequest = (held <= ws);
        if (!waitrequest) acc_cyc = cyc;
      end else begin
        waitrequest = 1'($urandom_range(0, 1));
      end
      readdata = (acc_cyc >= 0 && cyc == acc_cyc + LAT) ? rd : $urandom;
      if (rsp_valid) begin
        done = 1; rsp_cyc = cyc; got = rsp_rdata;
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", 32'(rsp_err), 32'(err));
        req_valid = 1'b0;
      end else begin
        // busy-time request noise must be ignored
        req_valid = 1'($urandom_range(0, 1));
        req_addr  = $urandom; req_wdata = $urandom; req_write = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    chk("rsp_seen", 32'(done), 32'd1);
    chk("rsp_cycle", 32'(rsp_cyc), 32'(exp_cyc));
    chk("bus_cycles", 32'(held), err ? 32'd0 : 32'(ws + 1));
    chk("rsp_pulse", 32'(rsp_valid), 32'd0);
    chk("ready_after", 32'(req_ready), 32'd1);
  endtask

  logic [31:0] got;

  initial begin
    #1;
    chk("rst_read", 32'(read), 32'd0);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_addr", address, 32'd0);
    chk("rst_be", 32'(byteenable), 32'd0);
    chk("rst_wdata", writedata, 32'd0);
    chk("rst_rsp", {rsp_rdata[30:0], rsp_valid}, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_pre_edge", 32'(req_ready), 32'd0);
    @(negedge clk);

    run_txn(0, 32'hBFC0_0004, 2'd2, 0, 32'h0, 32'h1234_5678, 0, got);
    chk("word_load", got, 32'h1234_5678);
    run_txn(0, 32'h0000_000B, 2'd0, 1, 32'h0, 32'h80FF_7F01, 0, got);
    chk("byte_signed", got, 32'hFFFF_FF80);
    run_txn(0, 32'h0000_000B, 2'd0, 0, 32'h0, 32'h80FF_7F01, 1, got);
    chk("byte_unsigned", got, 32'h0000_0080);
    run_txn(1, 32'h0000_0006, 2'd1, 0, 32'h0000_ABCD, 32'h0, 3, got);
    run_txn(0, 32'h0000_0002, 2'd2, 0, 32'h0, 32'hCAFE_F00D, 0, got);
`ifdef AVALON_MASTER_ALIGN_CHECK_EN
    chk("misal_rdata", got, 32'h0);
`else
    chk("unal_word", got, 32'hCAFE_F00D);
`endif

    // reset while a load is stalled on the bus
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h100; req_size = 2'd2;
    waitrequest = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("bus_read", 32'(read), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_read", 32'(read), 32'd0);
    chk("arst_addr", address, 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; waitrequest = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_rsp_after_rst", 32'(rsp_valid | read | write), 32'd0);
    end
    run_txn(0, 32'h0000_0010, 2'd1, 1, 32'h0, 32'h0000_8001, 2, got);
    chk("post_rst_load", got, 32'hFFFF_8001);

    for (int n = 0; n < 150; n++) begin
      run_txn(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 3), got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
